regwrite_arbiter: RTL
=====================

Name: regwrite_arbiter

Overview:
- Shares the single write port of a register-file bank (an array of Reg instances behind one address decoder) between NREQ requesters, e.g. ALU writeback, load unit and CSR unit.
- Round-robin arbitration with a per-cycle grant and a registered write stage, so that at most one register is written per clock.
- Sits between the execute/memory stages and the register file.
- Also exposes a pending-write indication that the hazard logic uses.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- BITS, 32, register data width.
- ABITS, 5, register address width.
- ZERO_RO, 1, when 1, writes to address 0 are granted but never reach the register file.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- hold  input  1  pipeline freeze; when 1, no grant is issued.
- req  input  NREQ  per-requester write request; held until granted.
- req_addr  input  NREQ*ABITS  flattened; requester i occupies bits [i*ABITS +: ABITS].
- req_data  input  NREQ*BITS  flattened; requester i occupies bits [i*BITS +: BITS].
- grant  output  NREQ  one-hot or zero; combinational this cycle.
- rf_wenable  output  1  registered write enable to the register file.
- rf_waddr  output  ABITS  registered write address.
- rf_wdata  output  BITS  registered write data.
- pending  output  1  high while a granted write has not yet reached the register file (equals rf_wenable).

Behaviour:
- Reset, asynchronous: ptr=0, rf_wenable=0, rf_waddr=0, rf_wdata=0, pending=0. grant is 0 while rst=1.
- State:
  - ptr (clog2(NREQ) bits) holds the index of the highest-priority requester.
  - The output stage register holds wenable, waddr and wdata.
- Grant, combinational:
  - If hold=0 and req!=0, grant the first i with req[i]=1, scanning ptr, ptr+1, ..., wrapping mod NREQ.
  - Otherwise grant=0.
  - grant has at most one bit set.
- Handshake:
  - The requester sees grant[i]=1 in cycle t. The transfer completes at the t→t+1 edge.
  - The requester deasserts req or presents its next write in t+1.
  - req_addr and req_data must be stable while req=1. No requester may withdraw req before it is granted.
- Pointer update on the edge ending a cycle with a grant to i: ptr <= (i+1) mod NREQ. With no grant, ptr holds.
- Write stage, latency exactly 1 cycle from grant:
  - rf_wenable <= |grant, except that it is forced to 0 when ZERO_RO=1 and the granted address is 0.
  - rf_waddr and rf_wdata load from the granted requester whenever a grant occurs, including the suppressed address-0 case.
  - With no grant: rf_wenable <= 0, and rf_waddr/rf_wdata hold their values.
- Back-to-back: a grant is allowed every cycle. Sustained throughput is one write per clock.
- hold=1: grant=0, ptr is frozen, and the next-cycle rf_wenable=0. A write already registered still completes; it is not cancelled.
- Reset mid-operation: rst asserted in the same cycle as a grant discards the transfer. The requester must re-request after reset.
- Single requester: it is granted every cycle it requests, regardless of ptr.
- NREQ not a power of 2: the ptr wrap uses an explicit compare to NREQ-1, not a mask.

Decomposition:
- Package regwrite_pkg:
  - Function clog2.
  - Typedefs for the address and data slices, parameterised through localparams in the module.
  - Constant ZERO_ADDR.
- One sub-module, rr_picker:
  - Purely combinational.
  - Inputs: req, ptr, enable.
  - Outputs: one-hot grant, binary index, valid flag.
- The arbiter owns ptr and the write stage.

Test Plan (NREQ=4, BITS=8, ABITS=3):
- Reset then idle: rst=1 then 0, req=0 → grant=0000, rf_wenable=0, rf_waddr=000, rf_wdata=00000000 for 4 cycles.
- Single write:
  - req=0010, addr1=3'd5, data1=8'hA5 → grant=0010 in that cycle.
  - The next cycle gives rf_wenable=1, rf_waddr=5, rf_wdata=A5, followed by rf_wenable=0.
- Round-robin fairness:
  - req=1111 held, with each requester's data equal to its index → grant sequence 0001, 0010, 0100, 1000, 0001.
  - rf_wdata follows 0, 1, 2, 3, 0, each one cycle later.
- Wrap priority:
  - After a grant to requester 3, req=1001 → grant=0001. The next grant, with req still 1001, is 1000.
- hold:
  - req=0100 with hold=1 for 3 cycles → grant=0000, rf_wenable=0, ptr unchanged.
  - When hold drops → grant=0100 immediately, then rf_wenable=1.
- Zero-register suppression:
  - ZERO_RO=1, req=0001, addr0=0, data0=FF → grant=0001.
  - The next cycle gives rf_wenable=0 and rf_waddr=0.
  - ptr advances, so a following req=0011 is granted to requester 1.

Source files
------------

// File: rtl/regwrite_pkg.sv
// Shared constants and helpers for the register-file write-port arbiter.
package regwrite_pkg;

  localparam int unsigned ZERO_ADDR = 0;

  // Bits needed to index n items, never less than 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/regwrite_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping mod NREQ.
module rr_picker
  import regwrite_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  localparam int unsigned PW = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  input  logic            enable_i,
  output logic [NREQ-1:0] grant_o,
  output logic [PW-1:0]   idx_o,
  output logic            valid_o
);

  always_comb begin
    int cand;
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    for (int k = 0; k < int'(NREQ); k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= int'(NREQ)) cand = cand - int'(NREQ);
      if (!valid_o && enable_i && req_i[PW'(cand)]) begin
        grant_o[PW'(cand)] = 1'b1;
        idx_o              = PW'(cand);
        valid_o            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regwrite_arbiter.sv
// Round-robin arbiter sharing one register-file write port, with a one-cycle
// registered write stage and a pending flag for hazard detection.
module regwrite_arbiter
  import regwrite_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned BITS    = 32,
  parameter int unsigned ABITS   = 5,
  parameter bit          ZERO_RO = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*ABITS-1:0] req_addr,
  input  logic [NREQ*BITS-1:0]  req_data,
  output logic [NREQ-1:0]       grant,
  output logic                  rf_wenable,
  output logic [ABITS-1:0]      rf_waddr,
  output logic [BITS-1:0]       rf_wdata,
  output logic                  pending
);

  localparam int unsigned PW = clog2(NREQ);

  typedef logic [ABITS-1:0] addr_t;
  typedef logic [BITS-1:0]  data_t;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] gnt_idx;
  logic          gnt_valid;
  logic          wen_q, wen_d;
  addr_t         waddr_q, waddr_d, sel_addr;
  data_t         wdata_q, wdata_d, sel_data;

  // Grants are masked during reset so a transfer in flight is discarded.
  rr_picker #(
    .NREQ(NREQ)
  ) u_picker (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .enable_i(!hold && !rst),
    .grant_o (grant),
    .idx_o   (gnt_idx),
    .valid_o (gnt_valid)
  );

  assign sel_addr = req_addr[32'(gnt_idx) * ABITS +: ABITS];
  assign sel_data = req_data[32'(gnt_idx) * BITS +: BITS];

  always_comb begin
    ptr_d   = ptr_q;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (gnt_valid) begin
      // Explicit compare keeps the wrap correct for non-power-of-2 NREQ.
      ptr_d   = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
      wen_d   = !(ZERO_RO && (sel_addr == ABITS'(ZERO_ADDR)));
      waddr_d = sel_addr;
      wdata_d = sel_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign rf_wenable = wen_q;
  assign rf_waddr   = waddr_q;
  assign rf_wdata   = wdata_q;
  assign pending    = wen_q;

endmodule
